demux_tree_pipe: RTL and testbench

- Parametrised 1-to-N registered demultiplexer; N = 2**SEL_W output channels, each DATA_W bits wide.
- Successor to the fixed 1x2..1x1024 demux trees. Adds configurable pipelining depth, per-channel valid, broadcast, global stall, and hold/clear mode for unselected channels.
- Sits between a single serial/IO source and wide register-rich fabric loads. It is the IO-register stress block for the max-IO benchmark family.

---
 rtl/demux_tree_pkg.sv | 16 +
 rtl/demux_tree_stage.sv | 83 ++++++++
 rtl/demux_tree_pipe.sv | 193 +++++++++++++++++++
 tb/tb_demux_tree_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_tree_pkg.sv
// demux_tree_pkg
//   Shared constants and helpers for the demux_tree_pipe codebase slice.
//   - MAX_SEL_W : largest supported select width.
//   - lat_f()   : number of register stages for a given select width and
//                 tree levels per stage (ceiling division).
//   The per-stage token struct (stage_t) depends on module parameters, so it
//   is declared inside each module from that module's localparam widths.
package demux_tree_pkg;

    localparam int MAX_SEL_W = 12;

    function automatic int lat_f(input int sel_w, input int reg_every);
        return (sel_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/demux_tree_stage.sv
// demux_tree_stage
//   One registered slice of the demux tree. It takes every node of the parent
//   level, resolves RES_W more select bits (MSB first) and registers
//   2**(PAR_LOG2+RES_W) child nodes. Child c = {parent index, resolved bits}.
//   A child is valid when its parent is valid and either the token is a
//   broadcast or the resolved bits route to it. Payload, bcast and remaining
//   select bits are copied regardless of valid.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears node valids)
//   en             1 = advance, 0 = every node holds
//   par_valid/par_bcast/par_sel/par_data   parent level, node-packed
//   child_valid/child_bcast/child_sel/child_data   registered child level
module demux_tree_stage
    import demux_tree_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int PAR_LOG2  = 0,
    parameter int RES_W     = 1,
    parameter int PAR_SEL_W = 2
) (
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic                                                       en,
    input  logic [(1<<PAR_LOG2)-1:0]                                   par_valid,
    input  logic [(1<<PAR_LOG2)-1:0]                                   par_bcast,
    input  logic [(1<<PAR_LOG2)*PAR_SEL_W-1:0]                         par_sel,
    input  logic [(1<<PAR_LOG2)*DATA_W-1:0]                            par_data,
    output logic [(1<<(PAR_LOG2+RES_W))-1:0]                           child_valid,
    output logic [(1<<(PAR_LOG2+RES_W))-1:0]                           child_bcast,
    output logic [(1<<(PAR_LOG2+RES_W))*(PAR_SEL_W-RES_W)-1:0]         child_sel,
    output logic [(1<<(PAR_LOG2+RES_W))*DATA_W-1:0]                    child_data
);

    localparam int CHILD_N     = 1 << (PAR_LOG2 + RES_W);
    localparam int FAN         = 1 << RES_W;
    localparam int CHILD_SEL_W = PAR_SEL_W - RES_W;

    typedef struct packed {
        logic                   valid;
        logic                   bcast;
        logic [CHILD_SEL_W-1:0] sel;
        logic [DATA_W-1:0]      data;
    } stage_t;

    for (genvar gi = 0; gi < CHILD_N; gi++) begin : g_node
        localparam int P = gi / FAN;
        localparam int B = gi % FAN;

        stage_t               node_d;
        stage_t               node_q;
        logic [PAR_SEL_W-1:0] par_sel_w;
        logic [RES_W-1:0]     route;

        assign par_sel_w = par_sel[P*PAR_SEL_W +: PAR_SEL_W];
        // The top RES_W bits of the parent's remaining select pick the branch.
        assign route     = par_sel_w[PAR_SEL_W-1 -: RES_W];

        always_comb begin
            node_d = node_q;
            if (en) begin
                node_d.valid = par_valid[P] & (par_bcast[P] | (route == RES_W'(B)));
                node_d.bcast = par_bcast[P];
                node_d.sel   = par_sel_w[CHILD_SEL_W-1:0];
                node_d.data  = par_data[P*DATA_W +: DATA_W];
            end
        end

        // Only valid needs clearing; payload is don't-care while invalid.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                node_q.valid <= 1'b0;
            end else begin
                node_q <= node_d;
            end
        end

        assign child_valid[gi]                              = node_q.valid;
        assign child_bcast[gi]                              = node_q.bcast;
        assign child_sel[gi*CHILD_SEL_W +: CHILD_SEL_W]     = node_q.sel;
        assign child_data[gi*DATA_W +: DATA_W]              = node_q.data;
    end

endmodule

// File: rtl/demux_tree_pipe.sv
// demux_tree_pipe
//   Parametrised 1-to-N registered demultiplexer tree, N = 2**SEL_W channels
//   of DATA_W bits. LAT = ceil(SEL_W/REG_EVERY) register stages; LAT-1 tree
//   slices (demux_tree_stage) followed by the per-channel output registers,
//   which resolve the remaining select bits.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (drops in-flight tokens)
//   en           pipeline advance; 0 = everything holds
//   in_valid     qualifies the input token
//   in_data      payload
//   in_sel       destination channel
//   in_bcast     deliver to every channel, in_sel ignored
//   out_data     channel k at [k*DATA_W +: DATA_W]
//   out_valid    one-cycle strobe per delivered channel
//   busy         any valid token inside the tree slices (output regs excluded)
//   deliver_cnt  saturating count of delivered tokens; only exists when the
//                macro DEMUX_TREE_CNT_EN is defined
// Parameters: DATA_W, SEL_W (1..12), REG_EVERY (1..SEL_W),
//   HOLD_UNSEL (0 = unselected channels clear, 1 = hold), CNT_W.
module demux_tree_pipe
    import demux_tree_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter int SEL_W      = 10,
    parameter int REG_EVERY  = 1,
    parameter int HOLD_UNSEL = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_bcast,
    output logic [(1<<SEL_W)*DATA_W-1:0]  out_data,
    output logic [(1<<SEL_W)-1:0]         out_valid,
    output logic                          busy
`ifdef DEMUX_TREE_CNT_EN
    ,
    output logic [CNT_W-1:0]              deliver_cnt
`endif
);

    localparam int N            = 1 << SEL_W;
    localparam int LAT          = lat_f(SEL_W, REG_EVERY);
    localparam int FIN_PAR_LOG2 = (LAT - 1) * REG_EVERY;
    localparam int FIN_PAR_N    = 1 << FIN_PAR_LOG2;
    localparam int FIN_SEL_W    = SEL_W - FIN_PAR_LOG2;

    // Parent level seen by the output stage.
    logic [FIN_PAR_N-1:0]           fin_valid;
    logic [FIN_PAR_N-1:0]           fin_bcast;
    logic [FIN_PAR_N*FIN_SEL_W-1:0] fin_sel;
    logic [FIN_PAR_N*DATA_W-1:0]    fin_data;

    // One OR-reduced valid per tree slice; the top bit stands for the output
    // stage, which is deliberately not part of busy.
    logic [LAT-1:0] rank_busy;
    assign rank_busy[LAT-1] = 1'b0;

    for (genvar gi = 0; gi < LAT - 1; gi++) begin : g_rank
        localparam int PL = gi * REG_EVERY;
        localparam int PW = SEL_W - PL;
        localparam int CL = PL + REG_EVERY;
        localparam int CW = PW - REG_EVERY;

        logic [(1<<PL)-1:0]        p_valid;
        logic [(1<<PL)-1:0]        p_bcast;
        logic [(1<<PL)*PW-1:0]     p_sel;
        logic [(1<<PL)*DATA_W-1:0] p_data;
        logic [(1<<CL)-1:0]        c_valid;
        logic [(1<<CL)-1:0]        c_bcast;
        logic [(1<<CL)*CW-1:0]     c_sel;
        logic [(1<<CL)*DATA_W-1:0] c_data;

        if (gi == 0) begin : g_src
            assign p_valid = in_valid;
            assign p_bcast = in_bcast;
            assign p_sel   = in_sel;
            assign p_data  = in_data;
        end else begin : g_chain
            assign p_valid = g_rank[gi-1].c_valid;
            assign p_bcast = g_rank[gi-1].c_bcast;
            assign p_sel   = g_rank[gi-1].c_sel;
            assign p_data  = g_rank[gi-1].c_data;
        end

        demux_tree_stage #(
            .DATA_W    (DATA_W),
            .PAR_LOG2  (PL),
            .RES_W     (REG_EVERY),
            .PAR_SEL_W (PW)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .par_valid   (p_valid),
            .par_bcast   (p_bcast),
            .par_sel     (p_sel),
            .par_data    (p_data),
            .child_valid (c_valid),
            .child_bcast (c_bcast),
            .child_sel   (c_sel),
            .child_data  (c_data)
        );

        assign rank_busy[gi] = |c_valid;
    end

    if (LAT == 1) begin : g_fin_direct
        assign fin_valid = in_valid;
        assign fin_bcast = in_bcast;
        assign fin_sel   = in_sel;
        assign fin_data  = in_data;
    end else begin : g_fin_tree
        assign fin_valid = g_rank[LAT-2].c_valid;
        assign fin_bcast = g_rank[LAT-2].c_bcast;
        assign fin_sel   = g_rank[LAT-2].c_sel;
        assign fin_data  = g_rank[LAT-2].c_data;
    end

    assign busy = |rank_busy;

    // Output registers: channel k listens to parent node k >> FIN_SEL_W and
    // matches the low FIN_SEL_W bits of k against that node's remaining sel.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        localparam int P = gi >> FIN_SEL_W;
        localparam int B = gi & ((1 << FIN_SEL_W) - 1);

        logic [FIN_SEL_W-1:0] psel;
        logic                 hit;
        logic                 valid_d;
        logic                 valid_q;
        logic [DATA_W-1:0]    data_d;
        logic [DATA_W-1:0]    data_q;

        assign psel = fin_sel[P*FIN_SEL_W +: FIN_SEL_W];
        assign hit  = fin_valid[P] & (fin_bcast[P] | (psel == FIN_SEL_W'(B)));

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (en) begin
                valid_d = hit;
                if (hit) begin
                    data_d = fin_data[P*DATA_W +: DATA_W];
                end else if (HOLD_UNSEL == 0) begin
                    data_d = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid[gi]                 = valid_q;
        assign out_data[gi*DATA_W +: DATA_W] = data_q;
    end

`ifdef DEMUX_TREE_CNT_EN
    // Every valid parent node at the output boundary belongs to the same
    // token (broadcast fans one token out), so any-valid counts exactly once.
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (|fin_valid) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign deliver_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_tree_pipe.sv
// tb_demux_tree_pipe
//   Drives three demux_tree_pipe instances from shared inputs:
//     dut0: SEL_W=3, REG_EVERY=1 (LAT=3), HOLD_UNSEL=0, CNT_W=16
//     dut1: SEL_W=4, REG_EVERY=3 (LAT=2), HOLD_UNSEL=1, CNT_W=2
//     dut2: SEL_W=2, REG_EVERY=2 (LAT=1), HOLD_UNSEL=0, CNT_W=3
//   A delay-line reference model predicts every output each cycle; directed
//   sequences with literal expectations pin the model, then random traffic.
module tb_demux_tree_pipe;

    localparam int ND = 3;
    localparam int LATS  [ND] = '{3, 2, 1};
    localparam int SELWS [ND] = '{3, 4, 2};
    localparam int HOLDS [ND] = '{0, 1, 0};
    localparam int CMAXS [ND] = '{65535, 3, 7};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bcast = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [3:0]  in_sel = 4'h0;

    logic [63:0]  od0;
    logic [7:0]   ov0;
    logic         b0;
    logic [127:0] od1;
    logic [15:0]  ov1;
    logic         b1;
    logic [31:0]  od2;
    logic [3:0]   ov2;
    logic         b2;
`ifdef DEMUX_TREE_CNT_EN
    logic [15:0]  c0;
    logic [1:0]   c1;
    logic [2:0]   c2;
`endif

    always #5 clk = ~clk;

    demux_tree_pipe #(.DATA_W(8), .SEL_W(3), .REG_EVERY(1), .HOLD_UNSEL(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_sel(in_sel[2:0]), .in_bcast(in_bcast), .out_data(od0), .out_valid(ov0), .busy(b0)
`ifdef DEMUX_TREE_CNT_EN
        , .deliver_cnt(c0)
`endif
    );

    demux_tree_pipe #(.DATA_W(8), .SEL_W(4), .REG_EVERY(3), .HOLD_UNSEL(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_data(od1), .out_valid(ov1), .busy(b1)
`ifdef DEMUX_TREE_CNT_EN
        , .deliver_cnt(c1)
`endif
    );

    demux_tree_pipe #(.DATA_W(8), .SEL_W(2), .REG_EVERY(2), .HOLD_UNSEL(0), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_sel(in_sel[1:0]), .in_bcast(in_bcast), .out_data(od2), .out_valid(ov2), .busy(b2)
`ifdef DEMUX_TREE_CNT_EN
        , .deliver_cnt(c2)
`endif
    );

    // ---------------- reference model: a plain LAT-deep delay line ----------
    bit          pv [ND][3];
    bit          pb [ND][3];
    logic [3:0]  ps [ND][3];
    logic [7:0]  pd [ND][3];
    logic [15:0] ev [ND];
    logic [7:0]  ed [ND][16];
    bit          eb [ND];
    int          ec [ND];

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b1;

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            int last;
            last = LATS[d] - 1;
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) pv[d][i] = 1'b0;
                ev[d] = '0;
                for (int k = 0; k < 16; k++) ed[d][k] = 8'h00;
                ec[d] = 0;
            end else if (en) begin
                for (int i = last; i > 0; i--) begin
                    pv[d][i] = pv[d][i-1];
                    pb[d][i] = pb[d][i-1];
                    ps[d][i] = ps[d][i-1];
                    pd[d][i] = pd[d][i-1];
                end
                pv[d][0] = in_valid;
                pb[d][0] = in_bcast;
                ps[d][0] = in_sel & 4'((1 << SELWS[d]) - 1);
                pd[d][0] = in_data;
                ev[d] = '0;
                for (int k = 0; k < (1 << SELWS[d]); k++) begin
                    if (pv[d][last] && (pb[d][last] || int'(ps[d][last]) == k)) begin
                        ev[d][k] = 1'b1;
                        ed[d][k] = pd[d][last];
                    end else if (HOLDS[d] == 0) begin
                        ed[d][k] = 8'h00;
                    end
                end
                if (pv[d][last] && ec[d] < CMAXS[d]) ec[d]++;
            end
            eb[d] = 1'b0;
            for (int i = 0; i < last; i++) eb[d] = eb[d] | pv[d][i];
        end
    endtask

    // ---------------- DUT accessors ----------------
    function automatic logic [15:0] act_valid(int d);
        case (d)
            0:       return {8'h00, ov0};
            1:       return ov1;
            default: return {12'h000, ov2};
        endcase
    endfunction

    function automatic logic [7:0] act_data(int d, int k);
        case (d)
            0:       return od0[k*8 +: 8];
            1:       return od1[k*8 +: 8];
            default: return od2[k*8 +: 8];
        endcase
    endfunction

    function automatic logic act_busy(int d);
        case (d)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

`ifdef DEMUX_TREE_CNT_EN
    function automatic logic [31:0] act_cnt(int d);
        case (d)
            0:       return {16'h0, c0};
            1:       return {30'h0, c1};
            default: return {29'h0, c2};
        endcase
    endfunction
`endif

    task automatic chk_eq(input string name, input int d, input int idx,
                          input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d idx%0d got %h exp %h at %0t", name, d, idx, got, exp, $time);
        end
    endtask

    // ---------------- the per-cycle compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < ND; d++) begin
                chk_eq("out_valid", d, -1, 32'(act_valid(d)), 32'(ev[d]));
                chk_eq("busy", d, -1, 32'(act_busy(d)), 32'(eb[d]));
                for (int k = 0; k < (1 << SELWS[d]); k++)
                    chk_eq("out_data", d, k, 32'(act_data(d, k)), 32'(ed[d][k]));
`ifdef DEMUX_TREE_CNT_EN
                chk_eq("deliver_cnt", d, -1, act_cnt(d), 32'(ec[d]));
`endif
            end
        end
    end

    // One clock: apply inputs, let the edge happen, advance the model, and
    // return at the following negedge where outputs are checked.
    task automatic step(input bit v, input logic [7:0] dat, input logic [3:0] s,
                        input bit bc, input bit e, input bit r);
        in_valid = v;
        in_data  = dat;
        in_sel   = s;
        in_bcast = bc;
        en       = e;
        rst_n    = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, 8'h00, 4'h0, 0, 1, 0);
        step(0, 8'h00, 4'h0, 0, 0, 0);
    endtask

    initial begin
        // Reset state, with en low on the second reset edge.
        do_reset();
        chk_eq("lit_rst_valid", 0, -1, 32'(ov0), 32'h0);
        chk_eq("lit_rst_data", 0, -1, od0[31:0], 32'h0);
        chk_eq("lit_rst_busy", 1, -1, 32'(b1), 32'h0);

        // Single token 0xA5 -> channel 5 of dut0 after 3 edges.
        step(1, 8'hA5, 4'd5, 0, 1, 1);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_a5_valid", 0, -1, 32'(ov0), 32'h20);
        chk_eq("lit_a5_data", 0, 5, 32'(od0[47:40]), 32'hA5);
        chk_eq("lit_a5_others", 0, -1, 32'({od0[63:48], od0[39:0]} == 56'h0), 32'h1);
        // Stall holds an asserted strobe.
        step(0, 8'h00, 4'd0, 0, 0, 1);
        chk_eq("lit_stall_hold", 0, -1, 32'(ov0), 32'h20);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_a5_clear", 0, -1, 32'(ov0), 32'h0);

        // Back-to-back tokens sel=0..7, data=0x10+sel.
        for (int j = 0; j < 10; j++) begin
            step(j < 8, 8'(8'h10 + j), 4'(j), 0, 1, 1);
            if (j >= 2) begin
                chk_eq("lit_b2b_valid", 0, j - 2, 32'(ov0), 32'(1 << (j - 2)));
                chk_eq("lit_b2b_data", 0, j - 2, 32'(od0[(j-2)*8 +: 8]), 32'(8'h10 + j - 2));
            end
        end

        // Broadcast 0x3C on the holding instance, then a bubble.
        step(1, 8'h3C, 4'd9, 1, 1, 1);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_bc_valid", 1, -1, 32'(ov1), 32'hFFFF);
        chk_eq("lit_bc_data", 1, 15, 32'(od1[127:120]), 32'h3C);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_bc_held_valid", 1, -1, 32'(ov1), 32'h0);
        chk_eq("lit_bc_held_data", 1, 0, 32'(od1[7:0]), 32'h3C);

        // Token to channel 2, then 4 stalled edges.
        do_reset();
        step(1, 8'h5A, 4'd2, 0, 1, 1);
        for (int j = 0; j < 4; j++) begin
            step(0, 8'h00, 4'd0, 0, 0, 1);
            chk_eq("lit_stall_busy", 0, j, 32'(b0), 32'h1);
            chk_eq("lit_stall_frozen", 0, j, 32'(ov0), 32'h0);
        end
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_stall_busy2", 0, -1, 32'(b0), 32'h1);
        step(0, 8'h00, 4'd0, 0, 1, 1);
        chk_eq("lit_stall_deliver", 0, -1, 32'(ov0), 32'h04);
        chk_eq("lit_stall_data", 0, 2, 32'(od0[23:16]), 32'h5A);

        // Reset with two tokens in flight: they must never be delivered.
        step(1, 8'h77, 4'd1, 0, 1, 1);
        step(1, 8'h88, 4'd6, 0, 1, 1);
        step(0, 8'h00, 4'd0, 0, 1, 0);
        chk_eq("lit_rst_busy0", 0, -1, 32'(b0), 32'h0);
        chk_eq("lit_rst_ov0", 0, -1, 32'(ov0), 32'h0);
        chk_eq("lit_rst_od0", 0, -1, od0[31:0] | od0[63:32], 32'h0);
        for (int j = 0; j < 3; j++) begin
            step(0, 8'h00, 4'd0, 0, 1, 1);
            chk_eq("lit_rst_drop", 0, j, 32'(ov0), 32'h0);
        end

`ifdef DEMUX_TREE_CNT_EN
        // dut1 (LAT=2, 2-bit counter): 5 tokens, one broadcast -> 1,2,3,3,3.
        begin
            int exp_cnt [5] = '{1, 2, 3, 3, 3};
            do_reset();
            for (int j = 0; j < 6; j++) begin
                step(j < 5, 8'(j), 4'(j), j == 2, 1, 1);
                if (j >= 1) chk_eq("lit_cnt", 1, j, 32'(c1), 32'(exp_cnt[j-1]));
            end
        end
`endif

        // Randomized traffic, including stalls and occasional resets.
        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(0, 9) < 7,
                 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 49) != 0);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
